// File: rtl/bruteforce_pkg.sv
// Shared constants for the bruteforce pipeline: candidate width, FIFO depth,
// hit counter width and the FIFO pointer-width helper.
package bruteforce_pkg;

  localparam int CAND_WIDTH = 64;
  localparam int DEF_DEPTH  = 16;
  localparam int HIT_CNT_W  = 32;

  // One extra bit beyond the address so full and empty differ after a wrap.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word, so the
// output is defined after reset and holds its last value while empty.
module hit_fifo
  import bruteforce_pkg::*;
#(
  parameter int WIDTH = CAND_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = ptr_w(DEPTH),
  localparam int AW   = PW - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = head_q;

  // The next head is either already in memory or is the word being written now.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_ptr_d != rd_ptr_d) begin
        if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) head_d = wdata;
        else                                                 head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hit_collector.sv
// Captures armed comparer hits into a FWFT FIFO with a saturating hit counter
// and sticky overflow. Optional duplicate suppression: HIT_COLLECTOR_DEDUP_EN.
module hit_collector
  import bruteforce_pkg::*;
#(
  parameter int WIDTH = CAND_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = HIT_CNT_W
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         din,
  input  logic                     good,
  input  logic                     arm,
  input  logic                     clear,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         hit_count,
  output logic                     overflow,
  output logic [ptr_w(DEPTH)-1:0]  level
);

  logic             hit, pop, push, drop, dup, full, empty;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  assign hit       = good & arm & ~clear;
  assign pop       = ~empty & out_ready & ~clear;
  assign push      = hit & ~dup & (~full | pop);
  assign drop      = hit & ~dup & full & ~pop;
  assign out_valid = ~empty;
  assign hit_count = cnt_q;
  assign overflow  = ovf_q;

`ifdef HIT_COLLECTOR_DEDUP_EN
  logic [WIDTH-1:0] last_q;
  logic             last_vld_q;

  assign dup = last_vld_q && (din == last_q);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (clear) begin
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_q     <= din;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Every armed hit counts, including dropped and suppressed ones.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (hit && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      if (drop)                 ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  hit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (din),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_hit_collector.sv
// Directed self-checking bench for hit_collector (default 64/16/32 build).
module tb_hit_collector;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic [63:0] din;
  logic        good, arm, clear, out_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic [31:0] hit_count;
  logic        overflow;
  logic [4:0]  level;

  int errorCount = 0;
  int checkCount = 0;

  hit_collector dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .din       (din),
    .good      (good),
    .arm       (arm),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hit_count (hit_count),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic g, input logic a, input logic c,
                               input logic r, input logic [63:0] d);
    good = g; arm = a; clear = c; out_ready = r; din = d;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pushWord(input logic [63:0] d);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, d);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
  endtask

  // Pops one word per cycle, checking it before the accepting edge.
  task automatic drainExpect(input string tag, input logic [63:0] expected);
    out_ready = 1'b1;
    checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput(tag, out_data, expected);
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 64'hDEAD);
    repeat (3) tick();
    checkOutput("rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_data",  out_data,            64'd0);
    checkOutput("rst_count", {32'd0, hit_count},  64'd0);
    checkOutput("rst_ovf",   {63'd0, overflow},   64'd0);
    checkOutput("rst_level", {59'd0, level},      64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    reset_n = 1'b1;
    tick();

    pushWord(64'h0123456789ABCDEF);
    checkOutput("one_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("one_data",  out_data, 64'h0123456789ABCDEF);
    checkOutput("one_count", {32'd0, hit_count}, 64'd1);
    checkOutput("one_level", {59'd0, level}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("pop_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("pop_hold",  out_data, 64'h0123456789ABCDEF);

    doClear();
    checkOutput("clr_count", {32'd0, hit_count}, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'h55);
    repeat (5) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkOutput("unarm_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("unarm_count", {32'd0, hit_count}, 64'd0);

    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 64'(i));
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    checkOutput("ovf_level", {59'd0, level}, 64'd16);
    checkOutput("ovf_flag",  {63'd0, overflow}, 64'd1);
    checkOutput("ovf_count", {32'd0, hit_count}, 64'd17);
    for (int i = 1; i <= 16; i++) drainExpect("ovf_drain", 64'(i));
    checkOutput("ovf_empty", {63'd0, out_valid}, 64'd0);
    checkOutput("ovf_sticky", {63'd0, overflow}, 64'd1);

    doClear();
    for (int i = 0; i < 16; i++) pushWord(64'(100 + i));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 64'd200);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    checkOutput("fullpop_ovf",   {63'd0, overflow}, 64'd0);
    checkOutput("fullpop_level", {59'd0, level}, 64'd16);
    checkOutput("fullpop_count", {32'd0, hit_count}, 64'd17);
    for (int i = 1; i < 16; i++) drainExpect("fullpop_drain", 64'(100 + i));
    drainExpect("fullpop_last", 64'd200);
    checkOutput("fullpop_empty", {59'd0, level}, 64'd0);

    for (int i = 0; i < 17; i++) pushWord(64'(300 + i));
    checkOutput("pre_clr_ovf", {63'd0, overflow}, 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'hBAD);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    checkOutput("clr_level", {59'd0, level}, 64'd0);
    checkOutput("clr_cnt",   {32'd0, hit_count}, 64'd0);
    checkOutput("clr_ovf",   {63'd0, overflow}, 64'd0);
    checkOutput("clr_valid", {63'd0, out_valid}, 64'd0);
    pushWord(64'hD00D);
    checkOutput("after_clr_data",  out_data, 64'hD00D);
    checkOutput("after_clr_level", {59'd0, level}, 64'd1);
    drainExpect("after_clr_pop", 64'hD00D);

    doClear();
    pushWord(64'hAAAA);
    pushWord(64'hAAAA);
    pushWord(64'hBBBB);
    checkOutput("dedup_count", {32'd0, hit_count}, 64'd3);
`ifdef HIT_COLLECTOR_DEDUP_EN
    checkOutput("dedup_level", {59'd0, level}, 64'd2);
    drainExpect("dedup_a", 64'hAAAA);
    drainExpect("dedup_b", 64'hBBBB);
`else
    checkOutput("dedup_level", {59'd0, level}, 64'd3);
    drainExpect("dedup_a0", 64'hAAAA);
    drainExpect("dedup_a1", 64'hAAAA);
    drainExpect("dedup_b",  64'hBBBB);
`endif

    pushWord(64'h11);
    pushWord(64'h22);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("async_data",  out_data, 64'd0);
    checkOutput("async_count", {32'd0, hit_count}, 64'd0);
    checkOutput("async_level", {59'd0, level}, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 64'h77);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("rst_ignore_count", {32'd0, hit_count}, 64'd0);
    checkOutput("rst_ignore_valid", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
